apb_reg_bank: RTL and testbench
===============================

APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of PWDATA, PRDATA and every register (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per TX and RX FIFO (power of two, >=2).
REQ-003 SHALL have the following ports; one clock; reset is asynchronous and active-low:
- PCLK  in  1  clock; all state on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSELx  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  8  register index in PADDR[7:5]; PADDR[4:0] ignored.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- prescale_reg, address_reg, command_reg  out  DATA_W  core configuration.
- core_busy, core_ack  in  1  core status.
- tx_rd_en  in  1  core pops TX FIFO.
- tx_data  out  DATA_W  TX FIFO head.
- tx_empty  out  1  TX FIFO empty.
- rx_wr_en  in  1  core pushes RX FIFO.
- rx_data  in  DATA_W  byte received by core.
- cmd_start  out  1  one-cycle start pulse.
- irq  out  1  interrupt, level.

Function
REQ-004 Index map SHALL be: 1 prescale RW, 2 address RW, 3 status R/W1C, 4 transmit WO (push TX), 5 receive RO (pop RX), 6 command RW, 7 irq_enable RW (macro only); 0 unmapped.
REQ-005 PREADY SHALL equal PSELx & PENABLE (zero wait states).
REQ-006 A write SHALL commit on the rising edge where PSELx & PENABLE & PWRITE & no error.
REQ-007 PRDATA SHALL be registered on the setup-phase edge (PSELx & !PENABLE & !PWRITE), held through the access phase, and be 0 otherwise.
REQ-008 Reading index 4 SHALL return 0 without error.
REQ-009 PSLVERR SHALL be 1 during the access phase, with no state change, for: unmapped index, write to 5, write to 4 when TX full, read of 5 when RX empty.
REQ-010 RX pop SHALL occur on the access-phase edge; the PRDATA value SHALL be the pre-pop head.
REQ-011 Status bits SHALL be: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] core_busy, [5] core_ack, [6] tx_ovf, [7] rx_ovf; upper bits 0.
REQ-012 tx_ovf SHALL set on a rejected TX push; rx_ovf SHALL set on rx_wr_en while RX full, with the data dropped; a status write of 1 SHALL clear each bit, and a set in the same cycle SHALL win.
REQ-013 TX/RX FIFOs SHALL use wrapping pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-014 Simultaneous push and pop SHALL be permitted when neither full nor empty, leaving the count unchanged.
REQ-015 Full/empty SHALL be evaluated before same-cycle pops or pushes: a push at full is rejected even if a pop occurs that cycle.
REQ-016 tx_rd_en while TX empty SHALL be ignored, with tx_data holding its last value.
REQ-017 A command write with PWDATA[7]=1 SHALL produce cmd_start=1 for exactly the next cycle; command_reg SHALL store PWDATA with bit 7 cleared one cycle later.

Reset
REQ-018 While PRESETn=0, all registers, PRDATA, cmd_start, irq and sticky flags SHALL be 0.
REQ-019 While PRESETn=0, both FIFOs SHALL be emptied (tx_empty=1, status=0x0A with core inputs 0).
REQ-020 Reset asserted mid-transfer SHALL abort the transfer with no commit; PREADY still follows REQ-005.

Configuration
REQ-021 With APB_REG_IRQ_EN defined:
- index 7 SHALL exist (bits [3:0] enable tx_empty, rx_full, tx_ovf, rx_ovf).
- irq SHALL be the OR of enabled status bits.
REQ-022 Without APB_REG_IRQ_EN:
- index 7 SHALL be unmapped (PSLVERR).
- irq SHALL be tied 0.
- the port list SHALL be unchanged.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- After reset, read index 3 -> PRDATA=0x0A, PSLVERR=0.
- Write 0x04 to index 1, 0x01 to index 2 -> prescale_reg=0x04, address_reg=0x01; read-back matches.
- Push 1..5 to index 4 with FIFO_DEPTH=4 -> 5th push PSLVERR=1; status=0x49; core pops return 1,2,3,4.
- Write 0x80 to index 6 -> cmd_start high exactly one cycle; then command_reg=0x00.
- Core pushes 0x02 into RX, bus reads index 5 twice -> 0x02 without error, then PSLVERR=1.
- With APB_REG_IRQ_EN, write 0x02 to index 7 and fill RX -> irq=1; read index 5 once -> irq=0.

Source files
------------

// File: rtl/apb_reg_bank.sv
// APB register bank with TX/RX FIFOs and a command-start pulse for a serial core.
// Define APB_REG_IRQ_EN to add the irq_enable register at index 7 and a live irq output.
module apb_reg_bank #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] prescale_reg,
  output logic [DATA_W-1:0] address_reg,
  output logic [DATA_W-1:0] command_reg,
  input  logic              core_busy,
  input  logic              core_ack,
  input  logic              tx_rd_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_empty,
  input  logic              rx_wr_en,
  input  logic [DATA_W-1:0] rx_data,
  output logic              cmd_start,
  output logic              irq
);

  localparam int unsigned     PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  localparam logic [2:0] IdxPrescale = 3'd1;
  localparam logic [2:0] IdxAddress  = 3'd2;
  localparam logic [2:0] IdxStatus   = 3'd3;
  localparam logic [2:0] IdxTx       = 3'd4;
  localparam logic [2:0] IdxRx       = 3'd5;
  localparam logic [2:0] IdxCommand  = 3'd6;
  localparam logic [2:0] IdxIrqEn    = 3'd7;

  logic [2:0]        idx;
  logic              setup, access, mapped, err;
  logic              wr_ok, status_wr, tx_push, tx_rej, tx_pop, rx_push, rx_pop;
  logic              tx_full, rx_full, rx_empty;
  logic [7:0]        status;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_paddr;

  logic [DATA_W-1:0] prescale_q, address_q;
  logic [DATA_W-1:0] command_q, command_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic              cmd_start_q, cmd_start_d;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0]   tx_cnt_q;
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   rx_wptr_q, rx_rptr_q;
  logic [CntW-1:0]   rx_cnt_q;

  // Low address bits select nothing; registers sit on 32-byte strides.
  assign unused_paddr = ^PADDR[4:0];
  assign idx          = PADDR[7:5];

  assign setup  = PSELx & ~PENABLE;
  assign access = PSELx & PENABLE;
  assign PREADY = access;

`ifdef APB_REG_IRQ_EN
  assign mapped = (idx != 3'd0);
`else
  assign mapped = (idx != 3'd0) && (idx != IdxIrqEn);
`endif

  assign tx_full  = (tx_cnt_q == CntFull);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntFull);
  assign rx_empty = (rx_cnt_q == '0);

  assign err = ~mapped
             | (PWRITE & (idx == IdxRx))
             | (PWRITE & (idx == IdxTx) & tx_full)
             | (~PWRITE & (idx == IdxRx) & rx_empty);

  assign PSLVERR   = access & err;
  assign wr_ok     = access & PWRITE & ~err;
  assign status_wr = wr_ok & (idx == IdxStatus);
  assign tx_push   = wr_ok & (idx == IdxTx);
  assign tx_rej    = access & PWRITE & (idx == IdxTx) & tx_full;
  assign tx_pop    = tx_rd_en & ~tx_empty;
  assign rx_push   = rx_wr_en & ~rx_full;
  assign rx_pop    = access & ~PWRITE & ~err & (idx == IdxRx);

  assign status = {rx_ovf_q, tx_ovf_q, core_ack, core_busy, rx_empty, rx_full, tx_empty, tx_full};

  assign tx_data      = tx_mem[tx_rptr_q];
  assign prescale_reg = prescale_q;
  assign address_reg  = address_q;
  assign command_reg  = command_q;
  assign cmd_start    = cmd_start_q;
  assign PRDATA       = prdata_q;

`ifdef APB_REG_IRQ_EN
  logic [3:0] irq_en_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en_q <= '0;
    end else if (wr_ok && idx == IdxIrqEn) begin
      irq_en_q <= PWDATA[3:0];
    end
  end

  assign irq = |(irq_en_q & {rx_ovf_q, tx_ovf_q, rx_full, tx_empty});
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (idx)
      IdxPrescale: rd_mux = prescale_q;
      IdxAddress:  rd_mux = address_q;
      IdxStatus:   rd_mux[7:0] = status;
      IdxRx:       rd_mux = rx_mem[rx_rptr_q];
      IdxCommand:  rd_mux = command_q;
`ifdef APB_REG_IRQ_EN
      IdxIrqEn:    rd_mux[3:0] = irq_en_q;
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    prdata_d    = (setup && !PWRITE) ? rd_mux : '0;
    cmd_start_d = wr_ok && (idx == IdxCommand) && PWDATA[7];
    command_d   = command_q;
    if (wr_ok && idx == IdxCommand) begin
      command_d = PWDATA;
    end else if (cmd_start_q) begin
      // The start bit is self-clearing once the pulse has been issued.
      command_d[7] = 1'b0;
    end
    // A new overflow event beats a same-cycle write-one-to-clear.
    tx_ovf_d = tx_rej | (tx_ovf_q & ~(status_wr & PWDATA[6]));
    rx_ovf_d = (rx_wr_en & rx_full) | (rx_ovf_q & ~(status_wr & PWDATA[7]));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prescale_q  <= '0;
      address_q   <= '0;
      command_q   <= '0;
      prdata_q    <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      cmd_start_q <= 1'b0;
    end else begin
      if (wr_ok && idx == IdxPrescale) prescale_q <= PWDATA;
      if (wr_ok && idx == IdxAddress)  address_q  <= PWDATA;
      command_q   <= command_d;
      prdata_q    <= prdata_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      cmd_start_q <= cmd_start_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr_q] <= PWDATA;
        tx_wptr_q         <= tx_wptr_q + PtrW'(1);
      end
      if (tx_pop) tx_rptr_q <= tx_rptr_q + PtrW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + CntW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - CntW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr_q] <= rx_data;
        rx_wptr_q         <= rx_wptr_q + PtrW'(1);
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + CntW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - CntW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: read expectations and TX pop order go through scoreboard queues.
module tb_apb_reg_bank;

  localparam int unsigned DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]    PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] prescale_reg, address_reg, command_reg;
  logic          core_busy = 1'b0, core_ack = 1'b0;
  logic          tx_rd_en = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_empty;
  logic          rx_wr_en = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          cmd_start, irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          err;
    logic          chk;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       rd_q[$];
  logic [DW-1:0] tx_q[$];

  apb_reg_bank #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .prescale_reg(prescale_reg), .address_reg(address_reg), .command_reg(command_reg),
    .core_busy(core_busy), .core_ack(core_ack), .tx_rd_en(tx_rd_en), .tx_data(tx_data),
    .tx_empty(tx_empty), .rx_wr_en(rx_wr_en), .rx_data(rx_data), .cmd_start(cmd_start),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  // Returns on the falling edge right after the access-phase commit edge.
  task automatic apb_write(input logic [2:0] idx, input logic [DW-1:0] d, output logic err);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {idx, 5'b10101}; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [DW-1:0] d, output logic err);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {idx, 5'b01010};
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rx_push_vals(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      rx_wr_en = 1'b1; rx_data = base + DW'(i);
    end
    @(negedge PCLK);
    rx_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic e;
    rd_exp_t x;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if ({PRDATA, prescale_reg, address_reg, command_reg} !== '0) begin n_bad++;
      $display("FAIL reset_regs: got %h want 0", {PRDATA, prescale_reg, address_reg, command_reg}); end
    n_cmp++; if ({cmd_start, irq} !== 2'b00) begin n_bad++; $display("FAIL reset_outs: got %b want 00", {cmd_start, irq}); end
    PRESETn = 1'b1;
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h0A});
    apb_read(3'd3, d, e);
    x = rd_q.pop_front();
    n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
      $display("FAIL reset_status: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data); end
  endtask

  task automatic test_rw();
    logic [DW-1:0] d;
    logic e1, e2;
    rd_exp_t x;
    apb_write(3'd1, 8'h04, e1);
    apb_write(3'd2, 8'h01, e2);
    n_cmp++; if ({e1, e2} !== 2'b00) begin n_bad++; $display("FAIL rw_write_err: got %b want 00", {e1, e2}); end
    n_cmp++; if (prescale_reg !== 8'h04 || address_reg !== 8'h01) begin n_bad++;
      $display("FAIL rw_regs: got %h/%h want 04/01", prescale_reg, address_reg); end
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h04});
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h01});
    for (int i = 0; i < 2; i++) begin
      apb_read((i == 0) ? 3'd1 : 3'd2, d, e1);
      x = rd_q.pop_front();
      n_cmp++; if (e1 !== x.err || d !== x.data) begin n_bad++;
        $display("FAIL rw_readback[%0d]: got err=%b data=%h want err=%b data=%h", i, e1, d, x.err, x.data); end
    end
  endtask

  task automatic test_tx_fifo();
    logic [DW-1:0] d, exp_d;
    logic e;
    rd_exp_t x;
    for (int i = 1; i <= 5; i++) begin
      apb_write(3'd4, DW'(i), e);
      if (i <= 4) tx_q.push_back(DW'(i));
      n_cmp++; if (e !== (i == 5)) begin n_bad++; $display("FAIL tx_push[%0d]: got err=%b want %b", i, e, i == 5); end
    end
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h49});
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h00});
    for (int i = 0; i < 2; i++) begin
      apb_read((i == 0) ? 3'd3 : 3'd4, d, e);
      x = rd_q.pop_front();
      n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
        $display("FAIL tx_status_read[%0d]: got err=%b data=%h want err=%b data=%h", i, e, d, x.err, x.data); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      exp_d = tx_q.pop_front();
      n_cmp++; if (tx_data !== exp_d) begin n_bad++; $display("FAIL tx_pop[%0d]: got %h want %h", i, tx_data, exp_d); end
      tx_rd_en = 1'b1;
    end
    @(negedge PCLK);
    tx_rd_en = 1'b0;
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL tx_drained: got %b want 1", tx_empty); end
    @(negedge PCLK);
    tx_rd_en = 1'b1;
    @(negedge PCLK);
    tx_rd_en = 1'b0;
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL tx_empty_pop: got %b want 1", tx_empty); end
    apb_write(3'd4, 8'h09, e);
    tx_q.push_back(8'h09);
    exp_d = tx_q.pop_front();
    n_cmp++; if (tx_data !== exp_d || tx_empty !== 1'b0) begin n_bad++;
      $display("FAIL tx_after_empty_pop: got %h/%b want %h/0", tx_data, tx_empty, exp_d); end
    @(negedge PCLK);
    tx_rd_en = 1'b1;
    @(negedge PCLK);
    tx_rd_en = 1'b0;
    apb_write(3'd3, 8'h40, e);
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h0A});
    apb_read(3'd3, d, e);
    x = rd_q.pop_front();
    n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
      $display("FAIL tx_ovf_clear: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data); end
  endtask

  task automatic test_cmd();
    logic e;
    apb_write(3'd6, 8'h80, e);
    n_cmp++; if (cmd_start !== 1'b1 || e !== 1'b0) begin n_bad++;
      $display("FAIL cmd_pulse: got start=%b err=%b want 1/0", cmd_start, e); end
    @(negedge PCLK);
    n_cmp++; if (cmd_start !== 1'b0 || command_reg !== 8'h00) begin n_bad++;
      $display("FAIL cmd_after: got start=%b cmd=%h want 0/00", cmd_start, command_reg); end
    apb_write(3'd6, 8'h05, e);
    n_cmp++; if (cmd_start !== 1'b0 || command_reg !== 8'h05) begin n_bad++;
      $display("FAIL cmd_nostart: got start=%b cmd=%h want 0/05", cmd_start, command_reg); end
  endtask

  task automatic test_rx();
    logic [DW-1:0] d;
    logic e;
    rd_exp_t x;
    rx_push_vals(8'h02, 1);
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h02});
    rd_q.push_back('{err: 1'b1, chk: 1'b0, data: 8'h00});
    for (int i = 0; i < 2; i++) begin
      apb_read(3'd5, d, e);
      x = rd_q.pop_front();
      n_cmp++; if (e !== x.err || (x.chk && d !== x.data)) begin n_bad++;
        $display("FAIL rx_single[%0d]: got err=%b data=%h want err=%b data=%h", i, e, d, x.err, x.data); end
    end
    rx_push_vals(8'h11, 5);
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h86});
    for (int i = 0; i < 4; i++) rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h11 + DW'(i)});
    for (int i = 0; i < 5; i++) begin
      apb_read((i == 0) ? 3'd3 : 3'd5, d, e);
      x = rd_q.pop_front();
      n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
        $display("FAIL rx_overflow[%0d]: got err=%b data=%h want err=%b data=%h", i, e, d, x.err, x.data); end
    end
    apb_write(3'd3, 8'h80, e);
    core_busy = 1'b1; core_ack = 1'b1;
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h3A});
    apb_read(3'd3, d, e);
    x = rd_q.pop_front();
    core_busy = 1'b0; core_ack = 1'b0;
    n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
      $display("FAIL rx_status_core: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data); end
  endtask

  task automatic test_errors();
    logic [DW-1:0] d;
    logic e;
    apb_read(3'd0, d, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_unmapped: got %b want 1", e); end
    apb_write(3'd5, 8'h33, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_write_rx: got %b want 1", e); end
    apb_write(3'd0, 8'h33, e);
    n_cmp++; if (e !== 1'b1 || prescale_reg !== 8'h04) begin n_bad++;
      $display("FAIL err_write_unmapped: got err=%b pre=%h want 1/04", e, prescale_reg); end
  endtask

  task automatic test_irq();
    logic [DW-1:0] d;
    logic e;
`ifdef APB_REG_IRQ_EN
    apb_write(3'd7, 8'h02, e);
    n_cmp++; if (e !== 1'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL irq_en_write: got err=%b irq=%b want 0/0", e, irq); end
    rx_push_vals(8'h20, 4);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rx_full: got %b want 1", irq); end
    apb_read(3'd5, d, e);
    n_cmp++; if (irq !== 1'b0 || d !== 8'h20) begin n_bad++; $display("FAIL irq_after_pop: got irq=%b d=%h want 0/20", irq, d); end
    for (int i = 0; i < 3; i++) apb_read(3'd5, d, e);
`else
    apb_write(3'd7, 8'h02, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL irq_idx7_unmapped: got %b want 1", e); end
    rx_push_vals(8'h20, 4);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_tied: got %b want 0", irq); end
    for (int i = 0; i < 4; i++) apb_read(3'd5, d, e);
`endif
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic e;
    rd_exp_t x;
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {3'd1, 5'b0}; PWDATA = 8'h55;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    n_cmp++; if (PREADY !== 1'b1 || prescale_reg !== 8'h00) begin n_bad++;
      $display("FAIL mid_reset: got ready=%b pre=%h want 1/00", PREADY, prescale_reg); end
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESETn = 1'b1;
    rd_q.push_back('{err: 1'b0, chk: 1'b1, data: 8'h00});
    apb_read(3'd1, d, e);
    x = rd_q.pop_front();
    n_cmp++; if (e !== x.err || d !== x.data) begin n_bad++;
      $display("FAIL mid_reset_readback: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_tx_fifo();
    test_cmd();
    test_rx();
    test_errors();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
